// File: rtl/tt_pin_resp_pkg.sv
// Shared types and constants for the Tiny Tapeout pin-protocol responder.
// Opcode and FSM state enums, register-file depth, output-enable masks
// and small combinational helpers.
package tt_pin_resp_pkg;

   localparam int         NREGS_DEF = 8;
   localparam logic [7:0] OE_BASE   = 8'h0C;
   localparam logic [7:0] OE_PAR    = 8'h1C;

   typedef enum logic [1:0] {
      OP_NOP    = 2'b00,
      OP_WRITE  = 2'b01,
      OP_READ   = 2'b10,
      OP_STATUS = 2'b11
   } opcode_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_CMD   = 2'b01,
      ST_WDATA = 2'b10,
      ST_RESP  = 2'b11
   } state_e;

   // Even parity over one byte (XOR of all bits)
   function automatic logic parity8(input logic [7:0] b);
      return ^b;
   endfunction

   // Opcodes that produce a response byte on uo_out
   function automatic logic is_resp_op(input opcode_e op);
      return (op == OP_READ) || (op == OP_STATUS);
   endfunction

endpackage

// File: rtl/tt_pin_sync.sv
// Multi-flop synchronizer for one asynchronous host pin, with an edge
// register so the level, rise and fall are all in the clk domain.
module tt_pin_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic lvl,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_r;
   logic                   prev_r;

   // Shift the pin through the synchronizer chain and remember the last level
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_r <= {SYNC_STAGES{1'b0}};
         prev_r <= 1'b0;
      end else begin
         sync_r <= {sync_r[SYNC_STAGES-2:0], d};
         prev_r <= sync_r[SYNC_STAGES-1];
      end
   end

   assign lvl  = sync_r[SYNC_STAGES-1];
   assign rise = sync_r[SYNC_STAGES-1] & ~prev_r;
   assign fall = ~sync_r[SYNC_STAGES-1] & prev_r;

endmodule

// File: rtl/tt_pin_responder.sv
// Device-side responder for the host pin protocol on ui_in/uio_in.
// Decodes NOP/WRITE/READ/STATUS commands against an 8x8 register file and
// returns response bytes on uo_out with a rsp_valid/rd_ack handshake.
// Optional feature: define TT_PIN_RESP_PARITY_EN to drive a parity bit on
// uio_out[4] while a response is valid (and enable that pin in uio_oe).
module tt_pin_responder
   import tt_pin_resp_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int NREGS       = NREGS_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uo_out,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   state_e     state_r;
   logic [7:0] byte_r;
   logic [7:0] regs_r [NREGS];
   logic [7:0] cmd_cnt_r;
   logic [7:0] uo_r;
   logic       ack_r;
   logic       rsp_valid_r;
   logic       pend_r;
   logic       par_s;

   logic       req_lvl_s, req_rise_s, req_fall_s;
   logic       rd_lvl_s, rd_rise_s, rd_fall_s;
   opcode_e    op_s;
   logic [2:0] addr_s;
   logic [7:0] resp_byte_s;

   tt_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_req_sync (
      .clk  (clk),
      .rst  (rst),
      .d    (uio_in[0]),
      .lvl  (req_lvl_s),
      .rise (req_rise_s),
      .fall (req_fall_s)
   );

   tt_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_rd_sync (
      .clk  (clk),
      .rst  (rst),
      .d    (uio_in[1]),
      .lvl  (rd_lvl_s),
      .rise (rd_rise_s),
      .fall (rd_fall_s)
   );

   assign op_s   = opcode_e'(byte_r[7:6]);
   assign addr_s = byte_r[2:0];

   // Select the byte a READ or STATUS command returns
   always_comb begin
      resp_byte_s = cmd_cnt_r;
      if (op_s == OP_READ) begin
         resp_byte_s = regs_r[addr_s];
      end else begin
         resp_byte_s = cmd_cnt_r;
      end
   end

   // Command FSM, register file, command counter and handshake outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         byte_r      <= 8'h00;
         cmd_cnt_r   <= 8'h00;
         uo_r        <= 8'h00;
         ack_r       <= 1'b0;
         rsp_valid_r <= 1'b0;
         pend_r      <= 1'b0;
         for (int i = 0; i < NREGS; i++) begin
            regs_r[i] <= 8'h00;
         end
      end else if (ena) begin
         case (state_r)
            ST_IDLE: begin
               // A response command held back by an unconsumed response
               if (pend_r) begin
                  if (!rsp_valid_r) begin
                     ack_r   <= 1'b1;
                     pend_r  <= 1'b0;
                     state_r <= ST_CMD;
                  end
               end else if (req_rise_s) begin
                  byte_r <= ui_in;
                  if (is_resp_op(opcode_e'(ui_in[7:6])) && rsp_valid_r) begin
                     pend_r <= 1'b1;
                  end else begin
                     ack_r   <= 1'b1;
                     state_r <= ST_CMD;
                  end
               end
            end
            ST_CMD: begin
               if (!req_lvl_s) begin
                  ack_r <= 1'b0;
                  case (op_s)
                     OP_NOP: begin
                        cmd_cnt_r <= cmd_cnt_r + 8'd1;
                        state_r   <= ST_IDLE;
                     end
                     OP_WRITE:  state_r <= ST_WDATA;
                     OP_READ:   state_r <= ST_RESP;
                     OP_STATUS: state_r <= ST_RESP;
                     default:   state_r <= ST_IDLE;
                  endcase
               end
            end
            ST_WDATA: begin
               // First capture and ack the data byte, then wait for req low
               if (!ack_r) begin
                  if (req_rise_s) begin
                     regs_r[addr_s] <= ui_in;
                     ack_r          <= 1'b1;
                  end
               end else if (!req_lvl_s) begin
                  ack_r     <= 1'b0;
                  cmd_cnt_r <= cmd_cnt_r + 8'd1;
                  state_r   <= ST_IDLE;
               end
            end
            ST_RESP: begin
               uo_r        <= resp_byte_s;
               rsp_valid_r <= 1'b1;
               cmd_cnt_r   <= cmd_cnt_r + 8'd1;
               state_r     <= ST_IDLE;
            end
            default: begin
               state_r <= ST_IDLE;
               ack_r   <= 1'b0;
            end
         endcase
         // Host consumed the response; a fresh load takes priority
         if (rd_rise_s && (state_r != ST_RESP)) begin
            rsp_valid_r <= 1'b0;
         end
      end
   end

`ifdef TT_PIN_RESP_PARITY_EN
   logic par_r;

   // Parity bit tracks the response byte while it is valid
   always_ff @(posedge clk) begin
      if (rst) begin
         par_r <= 1'b0;
      end else if (ena && (state_r == ST_RESP)) begin
         par_r <= parity8(resp_byte_s);
      end else if (ena && rd_rise_s) begin
         par_r <= 1'b0;
      end else begin
         par_r <= par_r;
      end
   end

   assign par_s  = par_r;
   assign uio_oe = OE_PAR;
`else
   assign par_s  = 1'b0;
   assign uio_oe = OE_BASE;
`endif

   assign uo_out  = uo_r;
   assign uio_out = {3'b000, par_s, rsp_valid_r, ack_r, 2'b00};

   logic unused_s;
   assign unused_s = ^{uio_in[7:2], byte_r[5:3], req_fall_s, rd_lvl_s, rd_fall_s};

endmodule

// File: tb/tb_tt_pin_responder.sv
// Self-checking bench for tt_pin_responder: bench-side model of the register
// file and command counter, expected response bytes queued at command time
// and compared when rsp_valid is seen.
module tb_tt_pin_responder;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ena = 1'b1;
   logic       req = 1'b0;
   logic       rd_ack = 1'b0;
   logic [7:0] ui_in = 8'h00;
   logic [7:0] uio_in;
   logic [7:0] uo_out, uio_out, uio_oe;

   int         checks = 0;
   int         failures = 0;
   logic [7:0] regs_m [8];
   logic [7:0] cnt_m;
   logic [7:0] exp_q [$];

   assign uio_in = {6'b110101, rd_ack, req};

   always #5 clk = ~clk;

   tt_pin_responder dut (
      .clk     (clk),
      .rst     (rst),
      .ena     (ena),
      .ui_in   (ui_in),
      .uio_in  (uio_in),
      .uo_out  (uo_out),
      .uio_out (uio_out),
      .uio_oe  (uio_oe)
   );

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < 8; i++) regs_m[i] = 8'h00;
      cnt_m = 8'h00;
      exp_q.delete();
   endtask

   task automatic do_reset();
      rst = 1'b1; req = 1'b0; rd_ack = 1'b0; ena = 1'b1;
      tick(2);
      rst = 1'b0;
      model_clear();
      tick(1);
   endtask

   // One host byte: raise req, wait for ack, drop req, wait for ack release
   task automatic send_byte(input logic [7:0] b, input bit chk_t, input string nm);
      int ae;
      int re;
      ui_in = b;
      req = 1'b1;
      ae = -1;
      for (int n = 0; n < 40; n++) begin
         @(posedge clk); #1;
         if (uio_out[2] === 1'b1) begin ae = n; break; end
      end
      checks++;
      if (ae < 0) begin
         failures++;
         $display("FAIL %s_ack_timeout: ack=%b required 1", nm, uio_out[2]);
      end else if (chk_t && ae != 2) begin
         failures++;
         $display("FAIL %s_ack_latency: ack edge=%0d required 2", nm, ae);
      end
      req = 1'b0;
      re = -1;
      for (int n = 0; n < 40; n++) begin
         @(posedge clk); #1;
         if (uio_out[2] === 1'b0) begin re = n; break; end
      end
      checks++;
      if (re < 0) begin
         failures++;
         $display("FAIL %s_release_timeout: ack=%b required 0", nm, uio_out[2]);
      end else if (chk_t && re != 2) begin
         failures++;
         $display("FAIL %s_release_latency: release edge=%0d required 2", nm, re);
      end
      ui_in = ~b;
   endtask

   task automatic do_nop(input logic [7:0] b);
      send_byte(b, 1'b1, "nop");
      cnt_m = cnt_m + 8'd1;
   endtask

   task automatic do_write(input logic [2:0] a, input logic [7:0] d);
      send_byte({2'b01, 3'b000, a}, 1'b1, "wr_cmd");
      send_byte(d, 1'b1, "wr_data");
      regs_m[a] = d;
      cnt_m = cnt_m + 8'd1;
   endtask

   task automatic do_read(input logic [2:0] a);
      send_byte({2'b10, 3'b000, a}, 1'b1, "rd");
      exp_q.push_back(regs_m[a]);
      cnt_m = cnt_m + 8'd1;
   endtask

   task automatic do_status(input logic [7:0] b);
      send_byte(b, 1'b1, "status");
      exp_q.push_back(cnt_m);
      cnt_m = cnt_m + 8'd1;
   endtask

   // Wait for a response, check it against the scoreboard, then consume it
   task automatic consume(input string nm);
      bit         got;
      int         ce;
      logic [7:0] exp;
      logic       exp_par;
      got = 1'b0;
      for (int n = 0; n < 40; n++) begin
         if (uio_out[3] === 1'b1) begin got = 1'b1; break; end
         tick(1);
      end
      checks++;
      if (!got) begin
         failures++;
         $display("FAIL %s_rsp_timeout: rsp_valid=%b required 1", nm, uio_out[3]);
      end else if (exp_q.size() == 0) begin
         failures++;
         $display("FAIL %s_unexpected_rsp: uo_out=%h with empty scoreboard", nm, uo_out);
      end else begin
         exp = exp_q.pop_front();
         checks++;
         if (uo_out !== exp) begin
            failures++;
            $display("FAIL %s_data: uo_out=%h required %h", nm, uo_out, exp);
         end
`ifdef TT_PIN_RESP_PARITY_EN
         exp_par = ^exp;
`else
         exp_par = 1'b0;
`endif
         checks++;
         if (uio_out[4] !== exp_par) begin
            failures++;
            $display("FAIL %s_parity: par=%b required %b", nm, uio_out[4], exp_par);
         end
         checks++;
         if ((uio_out & 8'hE3) !== 8'h00) begin
            failures++;
            $display("FAIL %s_uio_spare: uio_out=%h required spare bits 0", nm, uio_out);
         end
      end
      rd_ack = 1'b1;
      ce = -1;
      for (int n = 0; n < 40; n++) begin
         @(posedge clk); #1;
         if (uio_out[3] === 1'b0) begin ce = n; break; end
      end
      checks++;
      if (ce != 2) begin
         failures++;
         $display("FAIL %s_clear_latency: clear edge=%0d required 2", nm, ce);
      end
      rd_ack = 1'b0;
      tick(4);
   endtask

   task automatic test_reset();
      logic [7:0] exp_oe;
`ifdef TT_PIN_RESP_PARITY_EN
      exp_oe = 8'h1C;
`else
      exp_oe = 8'h0C;
`endif
      rst = 1'b1;
      tick(2);
      checks++;
      if (uo_out !== 8'h00) begin
         failures++; $display("FAIL reset_uo_out: got %h required 00", uo_out);
      end
      checks++;
      if (uio_out !== 8'h00) begin
         failures++; $display("FAIL reset_uio_out: got %h required 00", uio_out);
      end
      checks++;
      if (uio_oe !== exp_oe) begin
         failures++; $display("FAIL reset_uio_oe: got %h required %h", uio_oe, exp_oe);
      end
      rst = 1'b0;
      model_clear();
      tick(1);
   endtask

   task automatic test_write_read();
      do_reset();
      do_write(3'd5, 8'hA5);
      do_read(3'd5);
      checks++;
      if (uio_out[3] !== 1'b0) begin
         failures++; $display("FAIL rd_rsp_early: rsp_valid=%b required 0", uio_out[3]);
      end
      tick(1);
      checks++;
      if (uio_out[3] !== 1'b1) begin
         failures++; $display("FAIL rd_rsp_latency: rsp_valid=%b required 1", uio_out[3]);
      end
      consume("write_read");
   endtask

   task automatic test_status();
      do_reset();
      do_nop(8'h00);
      do_nop(8'h38);
      do_nop(8'h07);
      do_status(8'hC0);
      consume("status_first");
      do_status(8'hFF);
      consume("status_second");
   endtask

   task automatic test_backpressure();
      bit got;
      do_reset();
      do_write(3'd2, 8'h3C);
      do_write(3'd3, 8'h5A);
      do_read(3'd2);
      tick(2);
      ui_in = 8'h83;
      req = 1'b1;
      got = 1'b0;
      for (int n = 0; n < 10; n++) begin
         tick(1);
         if (uio_out[2] !== 1'b0) got = 1'b1;
      end
      checks++;
      if (got) begin
         failures++; $display("FAIL bp_ack_withheld: ack=1 seen required 0");
      end
      checks++;
      if (uio_out[3] !== 1'b1 || uo_out !== exp_q[0]) begin
         failures++;
         $display("FAIL bp_old_rsp: rsp_valid=%b uo_out=%h required 1 %h", uio_out[3], uo_out, exp_q[0]);
      end
      void'(exp_q.pop_front());
      rd_ack = 1'b1;
      got = 1'b0;
      for (int n = 0; n < 40; n++) begin
         tick(1);
         if (uio_out[2] === 1'b1) begin got = 1'b1; break; end
      end
      checks++;
      if (!got) begin
         failures++; $display("FAIL bp_ack_after_clear: ack=%b required 1", uio_out[2]);
      end
      checks++;
      if (uio_out[3] !== 1'b0) begin
         failures++; $display("FAIL bp_clear_first: rsp_valid=%b required 0", uio_out[3]);
      end
      exp_q.push_back(regs_m[3]);
      cnt_m = cnt_m + 8'd1;
      req = 1'b0;
      rd_ack = 1'b0;
      for (int n = 0; n < 40; n++) begin
         tick(1);
         if (uio_out[2] === 1'b0) break;
      end
      consume("bp_new_rsp");
   endtask

   task automatic test_wrap();
      do_reset();
      for (int i = 0; i < 256; i++) do_nop(8'h00);
      do_status(8'hC0);
      consume("wrap");
   endtask

   task automatic test_midframe_reset();
      do_reset();
      do_write(3'd5, 8'h77);
      do_read(3'd5);
      consume("pre_reset_read");
      send_byte(8'h45, 1'b1, "mid_wr_cmd");
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      model_clear();
      checks++;
      if (uio_out !== 8'h00 || uo_out !== 8'h00) begin
         failures++;
         $display("FAIL mid_reset_outputs: uio_out=%h uo_out=%h required 00 00", uio_out, uo_out);
      end
      tick(2);
      do_read(3'd5);
      consume("mid_reset_read");
   endtask

   task automatic test_ena();
      bit got;
      do_reset();
      ena = 1'b0;
      ui_in = 8'h00;
      req = 1'b1;
      tick(6);
      ena = 1'b1;
      got = 1'b0;
      for (int n = 0; n < 6; n++) begin
         tick(1);
         if (uio_out[2] !== 1'b0) got = 1'b1;
      end
      checks++;
      if (got) begin
         failures++; $display("FAIL ena_dropped_edge: ack=1 seen required 0");
      end
      req = 1'b0;
      tick(4);
      do_nop(8'h00);
      do_status(8'hC0);
      consume("ena_status");
   endtask

   initial begin
      model_clear();
      test_reset();
      test_write_read();
      test_status();
      test_backpressure();
      test_wrap();
      test_midframe_reset();
      test_ena();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

endmodule
